// File: rtl/hamming_decode_arbiter_pkg.sv
// rtl/hamming_decode_arbiter_pkg.sv - shared widths and syndrome-to-bit map for the Hamming(7,4) decoder
package hamming_decode_arbiter_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Syndrome value (1..7) to the code bit index it flags; entry 0 is never used.
  localparam logic [7:0][2:0] SYN_TO_BIT = {3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0};

endpackage

// File: rtl/hamming74_correct.sv
// rtl/hamming74_correct.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming74_correct
  import hamming_decode_arbiter_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome
);

  logic [CODE_W-1:0] fixed;

  // Compute syndrome, flip the flagged bit, and extract the data nibble
  always_comb begin
    syndrome[0] = code[0] ^ code[3] ^ code[4] ^ code[6];
    syndrome[1] = code[1] ^ code[3] ^ code[5] ^ code[6];
    syndrome[2] = code[2] ^ code[4] ^ code[5] ^ code[6];
    fixed = code;
    if (syndrome != '0) begin
      fixed[SYN_TO_BIT[syndrome]] = ~code[SYN_TO_BIT[syndrome]];
    end
    data = fixed[6:3];
  end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// rtl/hamming_decode_arbiter.sv - round-robin shared Hamming(7,4) decoder; HAMMING_ERR_COUNT_EN adds err_count
module hamming_decode_arbiter
  import hamming_decode_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [CODE_W*NUM_REQ-1:0] req_code,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SYN_W-1:0]          out_err_pos,
`ifdef HAMMING_ERR_COUNT_EN
  output logic [7:0]                err_count,
`endif
  output logic [ID_W-1:0]           out_id
);

  logic [ID_W-1:0]   last_q;
  logic              stage_free;
  logic              grant_any;
  logic              found;
  logic [ID_W:0]     sum;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] rot;
  logic [CODE_W-1:0] sel_code;
  logic [DATA_W-1:0] dec_data;
  logic [SYN_W-1:0]  dec_syn;

  assign stage_free = !out_valid || out_ready;

  // Round-robin pick: rotate so the requester after last_q sits at bit 0, take the lowest set bit
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ({1'b0, last_q} + 1'b1));
    found = 1'b0;
    sum   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, last_q} + (ID_W+1)'(j + 1);
      end
    end
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end
    grant_idx = sum[ID_W-1:0];
    grant_any = found && stage_free && rst_n;
    req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    sel_code  = CODE_W'(req_code >> (int'(grant_idx) * CODE_W));
  end

  hamming74_correct u_correct (
    .code     (sel_code),
    .data     (dec_data),
    .syndrome (dec_syn)
  );

  // Single-entry output register: load on a grant, otherwise drain when the consumer accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err_pos <= '0;
      out_id      <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else if (grant_any) begin
      out_valid   <= 1'b1;
      out_data    <= dec_data;
      out_err_pos <= dec_syn;
      out_id      <= grant_idx;
      last_q      <= grant_idx;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef HAMMING_ERR_COUNT_EN
  // Saturating count of accepted codewords that needed correction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (grant_any && dec_syn != '0 && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
